p2s_serializer: RTL

//   Parametrised parallel-to-serial converter with valid/ready input handshake.

---
 rtl/p2s_pkg.sv | 29 ++
 rtl/p2s_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/p2s_pkg.sv
// Shared types and frame-geometry constants for the parallel-to-serial block.
// Frame length depends on the P2S_PARITY_EN macro (adds one even-parity bit).
package p2s_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } p2s_state_e;

`ifdef P2S_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEF_WIDTH = 8;
  localparam int FRAME_LEN = DEF_WIDTH + PARITY_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  // Geometry helpers for a serializer instantiated with an arbitrary WIDTH.
  function automatic int frame_len_for(input int width);
    return width + PARITY_BITS;
  endfunction

  function automatic int cnt_w_for(input int width);
    return $clog2(width + PARITY_BITS);
  endfunction

endpackage

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with valid/ready intake and frame valid/last marking.
// Optional feature macro: P2S_PARITY_EN appends an even-parity bit to every frame.
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int LEN = frame_len_for(WIDTH);
  localparam int CW  = cnt_w_for(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LEN - 1);

  p2s_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             so_q, so_valid_q, so_last_q;

  logic             accept;
  logic             first_bit, head_bit, next_bit;
  logic [WIDTH-1:0] load_shift, step_shift;

`ifdef P2S_PARITY_EN
  logic             par_q;
`endif

  // Ready depends only on registered state, so a producer can never form a loop through it.
  assign pi_ready = (state_q == S_IDLE) || so_last_q;
  assign accept   = pi_valid && pi_ready;
  assign busy     = (state_q == S_SHIFT);
  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;

  // ---- FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (so_last_q && !accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- Bit ordering: the shift register always presents the next data bit at its head ----
  always_comb begin
    first_bit  = 1'b0;
    head_bit   = 1'b0;
    load_shift = '0;
    step_shift = '0;
    if (MSB_FIRST != 0) begin
      first_bit  = pi[WIDTH-1];
      load_shift = {pi[WIDTH-2:0], 1'b0};
      head_bit   = shift_q[WIDTH-1];
      step_shift = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit  = pi[0];
      load_shift = {1'b0, pi[WIDTH-1:1]};
      head_bit   = shift_q[0];
      step_shift = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

`ifdef P2S_PARITY_EN
  // With one bit left after the current one, the final slot belongs to parity.
  assign next_bit = (cnt_q == CW'(1)) ? par_q : head_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^pi;
    end
  end
`else
  assign next_bit = head_bit;
`endif

  // ---- Datapath: cnt_q counts bits still to follow the one currently on so ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else if (accept) begin
      shift_q    <= load_shift;
      cnt_q      <= CNT_LOAD;
      so_q       <= first_bit;
      so_valid_q <= 1'b1;
      so_last_q  <= 1'b0;
    end else if (state_q == S_SHIFT) begin
      if (cnt_q != '0) begin
        shift_q    <= step_shift;
        cnt_q      <= cnt_q - CW'(1);
        so_q       <= next_bit;
        so_valid_q <= 1'b1;
        so_last_q  <= (cnt_q == CW'(1));
      end else begin
        so_q       <= 1'b0;
        so_valid_q <= 1'b0;
        so_last_q  <= 1'b0;
      end
    end
  end

endmodule
